// File: rtl/letc_core_pkg.sv
// Shared memory-pipeline types for the LETC core: op/size/AMO encodings and
// the per-request metadata tracked between memory-1 issue and writeback.
package letc_core_pkg;

  // Widest supported XLEN; metadata carries operands at this width.
  localparam int XLEN_MAX = 64;

  typedef enum logic [1:0] {
    MEM_OP_NOP   = 2'd0,
    MEM_OP_LOAD  = 2'd1,
    MEM_OP_STORE = 2'd2,
    MEM_OP_AMO   = 2'd3
  } mem_op_e;

  typedef enum logic [1:0] {
    MEM_SIZE_BYTE     = 2'd0,
    MEM_SIZE_HALFWORD = 2'd1,
    MEM_SIZE_WORD     = 2'd2,
    MEM_SIZE_DOUBLE   = 2'd3
  } mem_size_e;

  typedef enum logic [3:0] {
    AMO_OP_SWAP = 4'd0,
    AMO_OP_ADD  = 4'd1,
    AMO_OP_AND  = 4'd2,
    AMO_OP_OR   = 4'd3,
    AMO_OP_XOR  = 4'd4,
    AMO_OP_MIN  = 4'd5,
    AMO_OP_MAX  = 4'd6,
    AMO_OP_MINU = 4'd7,
    AMO_OP_MAXU = 4'd8
  } amo_op_e;

  typedef struct packed {
    mem_op_e               op;
    mem_size_e             size;
    logic                  mem_signed;
    logic [2:0]            addr_lo;
    amo_op_e               amo_op;
    logic [XLEN_MAX-1:0]   rs2_val;
  } mem_rsp_meta_s;

endpackage

// File: rtl/letc_core_mem_load_align.sv
// Combinational load lane extraction and sign/zero extension for XLEN 32/64.
// Shared by the response path and any future load-forwarding path.
module letc_core_mem_load_align
  import letc_core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  mem_size_e        size,
  input  logic             mem_signed,
  input  logic [2:0]       addr_lo,
  input  logic [XLEN-1:0]  data,
  output logic [XLEN-1:0]  result
);

  logic [2:0]      off;
  logic [XLEN-1:0] lane;
  logic [XLEN-1:0] ext_b;
  logic [XLEN-1:0] ext_h;
  logic [XLEN-1:0] ext_w;

  // Byte offset of the addressed lane, aligned down to the access size.
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
    off = addr_lo;
    if (XLEN == 32) off[2] = 1'b0;
    case (size)
      MEM_SIZE_BYTE:     ;
      MEM_SIZE_HALFWORD: off[0] = 1'b0;
      MEM_SIZE_WORD:     off[1:0] = 2'b00;
      default:           off = 3'b000;
    endcase
  end

  assign lane  = data >> {off, 3'b000};
  assign ext_b = mem_signed ? XLEN'($signed(lane[7:0]))  : XLEN'(lane[7:0]);
  assign ext_h = mem_signed ? XLEN'($signed(lane[15:0])) : XLEN'(lane[15:0]);
  assign ext_w = mem_signed ? XLEN'($signed(lane[31:0])) : XLEN'(lane[31:0]);

  // DOUBLE on a 32-bit core degenerates to WORD.
  always_comb begin
    case (size)
      MEM_SIZE_BYTE:     result = ext_b;
      MEM_SIZE_HALFWORD: result = ext_h;
      MEM_SIZE_WORD:     result = ext_w;
      default:           result = (XLEN == 64) ? lane : ext_w;
    endcase
  end

endmodule

// File: rtl/letc_core_mem_rsp_unit.sv
// In-order DMSS response pairing: metadata FIFO, flush drain, load alignment and
// AMO write data. AMO ALU is built only when LETC_MEM_RSP_AMO_EN is defined.
module letc_core_mem_rsp_unit
  import letc_core_pkg::*;
#(
  parameter  int XLEN  = 32,
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_mem_op,
  input  logic [1:0]       in_mem_size,
  input  logic             in_mem_signed,
  input  logic [2:0]       in_addr_lo,
  input  logic [3:0]       in_amo_op,
  input  logic [XLEN-1:0]  in_rs2_val,
  input  logic             rsp_valid,
  output logic             rsp_ready,
  input  logic [XLEN-1:0]  rsp_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_mem_op,
  output logic [XLEN-1:0]  out_rdata,
  output logic [XLEN-1:0]  out_amo_wdata,
  output logic [CNT_W-1:0] outstanding
);

  localparam int PTR_W = $clog2(DEPTH);

  mem_rsp_meta_s    fifo_mem [DEPTH];
  mem_rsp_meta_s    in_meta;
  mem_rsp_meta_s    head;
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count, pend_cnt, drain_cnt;
  logic             head_valid, head_needs_rsp, slot_free, enq, complete, rsp_hs;
  logic [XLEN-1:0]  head_rs2, load_val, rdata_next, amo_wdata;
  logic             unused_meta;

  always_comb begin
    in_meta.op         = mem_op_e'(in_mem_op);
    in_meta.size       = mem_size_e'(in_mem_size);
    in_meta.mem_signed = in_mem_signed;
    in_meta.addr_lo    = in_addr_lo;
    in_meta.amo_op     = amo_op_e'(in_amo_op);
    in_meta.rs2_val    = XLEN_MAX'(in_rs2_val);
  end

  assign head           = fifo_mem[rd_ptr];
  assign head_rs2       = head.rs2_val[XLEN-1:0];
  assign unused_meta    = ^head;
  assign head_valid     = (count != '0);
  assign head_needs_rsp = (head.op != MEM_OP_NOP);
  assign in_ready       = (count != CNT_W'(DEPTH));
  assign enq            = in_valid && in_ready && !flush;
  assign slot_free      = !out_valid || out_ready;
  assign complete       = head_valid && slot_free && (drain_cnt == '0) && (!head_needs_rsp || rsp_valid);
  assign rsp_ready      = (drain_cnt != '0) || (head_valid && head_needs_rsp && slot_free);
  assign rsp_hs         = rsp_valid && rsp_ready;
  assign outstanding    = count;

  // NOTE: metadata storage has no reset; the pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (enq) fifo_mem[wr_ptr] <= in_meta;
  end

  // pend_cnt tracks non-NOP entries so a flush knows how many stale responses to swallow.
  // Upstream must keep drain_cnt + pend_cnt within CNT_W across back-to-back flushes.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state is written only with non-blocking assignments.
    if (!rst_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      pend_cnt  <= '0;
      drain_cnt <= '0;
    end else if (flush) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      pend_cnt  <= '0;
      drain_cnt <= drain_cnt + pend_cnt - CNT_W'(rsp_hs);
    end else begin
      if (enq)      wr_ptr <= wr_ptr + PTR_W'(1);
      if (complete) rd_ptr <= rd_ptr + PTR_W'(1);
      count    <= count + CNT_W'(enq) - CNT_W'(complete);
      pend_cnt <= pend_cnt + CNT_W'(enq && (in_meta.op != MEM_OP_NOP))
                           - CNT_W'(complete && head_needs_rsp);
      if (rsp_hs && (drain_cnt != '0)) drain_cnt <= drain_cnt - CNT_W'(1);
    end
  end

  letc_core_mem_load_align #(.XLEN(XLEN)) u_load_align (
    .size       (head.size),
    .mem_signed (head.mem_signed),
    .addr_lo    (head.addr_lo),
    .data       (rsp_data),
    .result     (load_val)
  );

  always_comb begin
    case (head.op)
      MEM_OP_NOP:   rdata_next = '0;
      MEM_OP_STORE: rdata_next = rsp_data;
      default:      rdata_next = load_val;
    endcase
  end

`ifdef LETC_MEM_RSP_AMO_EN
  logic            amo_word;
  mem_size_e       amo_size;
  logic [XLEN-1:0] amo_a, amo_b, amo_r;

  // Word AMOs run on sign-extended operands; this keeps both signed and unsigned ordering.
  assign amo_word = !((XLEN == 64) && (head.size == MEM_SIZE_DOUBLE));
  assign amo_size = amo_word ? MEM_SIZE_WORD : MEM_SIZE_DOUBLE;
  assign amo_b    = amo_word ? XLEN'($signed(head_rs2[31:0])) : head_rs2;

  letc_core_mem_load_align #(.XLEN(XLEN)) u_amo_align (
    .size       (amo_size),
    .mem_signed (1'b1),
    .addr_lo    (head.addr_lo),
    .data       (rsp_data),
    .result     (amo_a)
  );

  always_comb begin
    case (head.amo_op)
      AMO_OP_ADD:  amo_r = amo_a + amo_b;
      AMO_OP_AND:  amo_r = amo_a & amo_b;
      AMO_OP_OR:   amo_r = amo_a | amo_b;
      AMO_OP_XOR:  amo_r = amo_a ^ amo_b;
      AMO_OP_MIN:  amo_r = ($signed(amo_a) < $signed(amo_b)) ? amo_a : amo_b;
      AMO_OP_MAX:  amo_r = ($signed(amo_a) > $signed(amo_b)) ? amo_a : amo_b;
      AMO_OP_MINU: amo_r = (amo_a < amo_b) ? amo_a : amo_b;
      AMO_OP_MAXU: amo_r = (amo_a > amo_b) ? amo_a : amo_b;
      default:     amo_r = amo_b;
    endcase
    if (amo_word) amo_r = XLEN'($signed(amo_r[31:0]));
  end

  assign amo_wdata = (head.op == MEM_OP_AMO) ? amo_r : head_rs2;
`else
  assign amo_wdata = head_rs2;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_mem_op    <= '0;
      out_rdata     <= '0;
      out_amo_wdata <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (complete) begin
      out_valid     <= 1'b1;
      out_mem_op    <= head.op;
      out_rdata     <= rdata_next;
      out_amo_wdata <= amo_wdata;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assert property (@(posedge clk) disable iff (!rst_n)
                   !(rsp_valid && !head_valid && (drain_cnt == '0)))
    else $error("DMSS response arrived with no outstanding request");

endmodule

// File: doc/letc_core_mem_rsp_unit.md
Name: letc_core_mem_rsp_unit

Overview:
- Parametrised successor to the single-slot memory-2 response logic.
- Tracks up to DEPTH outstanding DMSS requests in order and pairs each in-order DMSS response with its request metadata.
- Extracts, aligns and sign-/zero-extends load data for XLEN 32 or 64, and computes AMO write data.
- Drains responses belonging to flushed requests. Sits between memory-1 request issue and writeback.

Parameters:
- XLEN, 32: data width; legal values 32 or 64.
- DEPTH, 4: maximum outstanding requests (metadata FIFO depth); power of two, 2 to 16.
- CNT_W, $clog2(DEPTH+1): occupancy and drain counter width (derived; do not override).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  discard all tracked requests and the output slot
- in_valid  in  1  request metadata valid
- in_ready  out  1  metadata FIFO can accept
- in_mem_op  in  2  mem_op_e: NOP/LOAD/STORE/AMO
- in_mem_size  in  2  mem_size_e: BYTE/HALFWORD/WORD/DOUBLE
- in_mem_signed  in  1  sign-extend load
- in_addr_lo  in  3  address low bits (bit 2 ignored when XLEN=32)
- in_amo_op  in  4  amo_op_e
- in_rs2_val  in  XLEN  store/AMO operand
- rsp_valid  in  1  DMSS response valid
- rsp_ready  out  1  response consumed
- rsp_data  in  XLEN  raw DMSS data (naturally aligned container)
- out_valid  out  1  result valid to writeback
- out_ready  in  1  writeback accepts
- out_mem_op  out  2  op of the result
- out_rdata  out  XLEN  extended load value
- out_amo_wdata  out  XLEN  AMO store data
- outstanding  out  CNT_W  FIFO occupancy

Behaviour:
- Reset: FIFO empty; outstanding=0; drain_cnt=0; out_valid=0; out_* data=0; in_ready=1; rsp_ready=0.
- Enqueue when in_valid && in_ready && !flush. in_ready = (outstanding != DEPTH), with no combinational dependence on dequeue. A full FIFO never accepts, even when it dequeues in the same cycle.
- Head needs a response iff mem_op != NOP.
- slot_free = !out_valid || out_ready.
- Head completes when FIFO is non-empty, slot_free, drain_cnt==0, and either the head is NOP or rsp_valid.
- On completion: pop the head and register the result; out_valid=1 the next cycle. Latency is 1 cycle from response to out_valid.
- rsp_ready = (drain_cnt != 0) || (head valid && head needs response && slot_free).
- When drain_cnt != 0, each response handshake decrements drain_cnt and is discarded.
- out_valid clears on out_ready when there is no new completion. Result holds stable while out_valid && !out_ready.
- Flush:
  - FIFO cleared; out_valid=0.
  - drain_cnt becomes drain_cnt + (count of non-NOP entries still awaiting a response), minus 1 if a response handshakes that cycle.
  - Same-cycle enqueue is dropped.
- Extraction:
  - Select the halfword, byte or word lane by in_addr_lo.
  - BYTE/HALFWORD/WORD are extended to XLEN using mem_signed. WORD is always sign-extended when XLEN=64 and mem_signed=1.
  - DOUBLE passes through. DOUBLE with XLEN=32 is treated as WORD.
  - STORE: out_rdata = raw rsp_data. NOP: out_rdata = 0.
- AMO: operand = extracted word (size WORD or DOUBLE).
  - out_amo_wdata = swap/add/and/or/xor/min/max/minu/maxu(operand, rs2) at operand width, truncated then sign-extended to XLEN.
  - Non-AMO ops: out_amo_wdata = rs2_val.
- Underflow: a response with empty FIFO and drain_cnt==0 is never acked (rsp_ready=0). A simulation assertion flags this.

Optional Feature:
- LETC_MEM_RSP_AMO_EN.
- Defined: AMO ALU is present as described.
- Undefined: the AMO ALU is removed; AMO is handled exactly as LOAD, out_amo_wdata = rs2_val, and in_amo_op is unused.

Decomposition:
- letc_core_pkg holds:
  - mem_op_e, mem_size_e and amo_op_e (MEM_SIZE_DOUBLE added).
  - The mem_rsp_meta_s struct: op, size, signed, addr_lo, amo_op, rs2_val.
- One sub-module: letc_core_mem_load_align.
  - Purely combinational extraction and extension.
  - Parametrised by XLEN.
  - Reusable by a future load-forwarding path.

Test Plan:
- XLEN=32: enqueue LOAD BYTE signed with addr_lo=3, then rsp_data=0x80FF_0000 -> next cycle out_valid=1, out_rdata=0xFFFF_FF80.
- XLEN=64: enqueue LOAD WORD signed with addr_lo=4, then rsp_data=0x9000_0000_0000_0001 -> out_rdata=0xFFFF_FFFF_9000_0000.
- DEPTH=4: issue 4 LOADs with no responses -> in_ready=0, outstanding=4. Then one response -> in_ready=1 the cycle after the pop.
- Issue 3 LOADs and flush before any response -> out_valid stays 0 and drain_cnt=3. The next 3 responses are acked and discarded. A fourth LOAD issued afterwards returns its own data.
- AMO MINU with memory word 0x0000_0005 and rs2=0xFFFF_FFFF -> out_amo_wdata=0x0000_0005. With LETC_MEM_RSP_AMO_EN undefined -> out_amo_wdata=0xFFFF_FFFF.
- Hold out_ready=0 with a NOP then a LOAD queued -> the NOP result holds stable and rsp_ready=0. Release out_ready -> the LOAD completes 1 cycle after its response.
